// File: rtl/au_seq_pkg.sv
// au_seq_pkg: shared definitions for the arithmetic-unit sequencer.
//   WIDTH_DEFAULT : default datapath width (must match the arithmetic unit)
//   OP_*          : command op-codes carried on cmd_op
//   state_t       : sequencer FSM states
//   flags_t       : status flag bundle held by the sequencer
package au_seq_pkg;

    localparam int unsigned WIDTH_DEFAULT = 5;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_CMP  = 3'b011;
    localparam logic [2:0] OP_CLR  = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    typedef struct packed {
        logic carry;
        logic zero;
        logic eq;
        logic err;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/au_seq_if.sv
// au_seq_if: command handshake plus arithmetic-unit bus of the sequencer.
//   cmd_valid/cmd_ready/cmd_op/cmd_data : command channel (valid/ready)
//   au_a/au_b/au_carry_in/au_chave      : drive into the combinational unit
//   au_result/au_carry_out/au_igualdade : unit outputs sampled by the sequencer
// Modports:
//   slave  : the sequencer
//   master : the command source
//   unit   : the combinational arithmetic unit
interface au_seq_if
    import au_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;

    logic [WIDTH-1:0] au_a;
    logic [WIDTH-1:0] au_b;
    logic             au_carry_in;
    logic             au_chave;
    logic [WIDTH-1:0] au_result;
    logic             au_carry_out;
    logic             au_igualdade;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        input  au_result, au_carry_out, au_igualdade,
        output cmd_ready,
        output au_a, au_b, au_carry_in, au_chave
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready
    );

    modport unit (
        input  au_a, au_b, au_carry_in, au_chave,
        output au_result, au_carry_out, au_igualdade
    );

endinterface

// File: rtl/au_seq_flags.sv
// au_seq_flags: combinational next-accumulator / next-flag logic.
//   op           : latched command op-code
//   acc          : current accumulator (also the unit's operand A)
//   data         : latched operand (the unit's operand B)
//   au_result    : unit result
//   au_carry_out : unit carry-out
//   au_igualdade : unit equality
//   flags        : current flags
//   acc_next     : accumulator value to commit at the end of EXEC
//   flags_next   : flag values to commit at the end of EXEC
// Optional: AU_SEQ_OVERFLOW_EN enables signed-overflow tracking on ADD/SUB;
// otherwise ovf is held at 0.
module au_seq_flags
    import au_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] au_result,
    input  logic             au_carry_out,
    input  logic             au_igualdade,
    input  flags_t           flags,
    output logic [WIDTH-1:0] acc_next,
    output flags_t           flags_next
);

`ifdef AU_SEQ_OVERFLOW_EN
    logic sign_b_eff;
    // The unit sees ~B on SUB because carry_in is 1 exactly for SUB in EXEC.
    assign sign_b_eff = data[WIDTH-1] ^ (op == OP_SUB);
`endif

    always_comb begin
        acc_next   = acc;
        flags_next = flags;
        case (op)
            OP_LOAD: begin
                acc_next        = data;
                flags_next.zero = (data == '0);
            end
            OP_ADD, OP_SUB: begin
                acc_next         = au_result;
                flags_next.carry = au_carry_out;
                flags_next.zero  = (au_result == '0);
`ifdef AU_SEQ_OVERFLOW_EN
                flags_next.ovf   = (acc[WIDTH-1] == sign_b_eff) &&
                                   (au_result[WIDTH-1] != acc[WIDTH-1]);
`endif
            end
            OP_CMP: begin
                flags_next.eq = au_igualdade;
            end
            OP_CLR: begin
                acc_next        = '0;
                flags_next      = '0;
                flags_next.zero = 1'b1;
            end
            default: begin
                flags_next.err = 1'b1;
            end
        endcase
`ifndef AU_SEQ_OVERFLOW_EN
        flags_next.ovf = 1'b0;
`endif
    end

endmodule

// File: rtl/au_sequencer.sv
// au_sequencer: command-driven controller for the combinational 5-bit
// arithmetic unit. One command at a time: IDLE -> EXEC -> RESP -> IDLE.
//   clk, rst_n     : rising-edge clock, asynchronous active-low reset
//   bus (slave)    : command handshake and arithmetic-unit signals
//   acc            : accumulator
//   flag_carry     : carry / no-borrow of the last ADD/SUB
//   flag_zero      : accumulator is zero after LOAD/ADD/SUB/CLR
//   flag_eq        : result of the last CMP
//   flag_err       : sticky illegal-op flag, cleared by CLR
//   flag_ovf       : signed overflow of the last ADD/SUB (AU_SEQ_OVERFLOW_EN),
//                    otherwise tied to 0
//   done           : one-cycle pulse in RESP when a command retires
module au_sequencer
    import au_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    au_seq_if.slave          bus,
    output logic [WIDTH-1:0] acc,
    output logic             flag_carry,
    output logic             flag_zero,
    output logic             flag_eq,
    output logic             flag_err,
    output logic             flag_ovf,
    output logic             done
);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_next;
    flags_t           flags_q;
    flags_t           flags_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        accept          = 1'b0;
        bus.cmd_ready   = 1'b0;
        bus.au_carry_in = 1'b0;
        bus.au_chave    = 1'b0;
        done            = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                bus.au_carry_in = (op_q == OP_SUB);
                bus.au_chave    = (op_q == OP_CMP);
                state_next      = RESP;
            end
            RESP: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_LOAD;
            data_q  <= '0;
            acc_q   <= '0;
            flags_q <= '0;
        end else begin
            if (accept) begin
                op_q   <= bus.cmd_op;
                data_q <= bus.cmd_data;
            end
            if (state == EXEC) begin
                acc_q   <= acc_next;
                flags_q <= flags_next;
            end
        end
    end

    au_seq_flags #(
        .WIDTH(WIDTH)
    ) u_flags (
        .op           (op_q),
        .acc          (acc_q),
        .data         (data_q),
        .au_result    (bus.au_result),
        .au_carry_out (bus.au_carry_out),
        .au_igualdade (bus.au_igualdade),
        .flags        (flags_q),
        .acc_next     (acc_next),
        .flags_next   (flags_next)
    );

    assign bus.au_a   = acc_q;
    assign bus.au_b   = data_q;
    assign acc        = acc_q;
    assign flag_carry = flags_q.carry;
    assign flag_zero  = flags_q.zero;
    assign flag_eq    = flags_q.eq;
    assign flag_err   = flags_q.err;
    assign flag_ovf   = flags_q.ovf;

endmodule

// File: tb/tb_au_sequencer.sv
// tb_au_sequencer: self-checking bench for au_sequencer. Contains a
// behavioural model of the arithmetic unit, a command-level reference model
// of the sequencer, a per-cycle compare process, and directed sequences with
// hand-computed expectations.
module tb_au_sequencer;

    localparam int unsigned W = 5;

    logic       clk;
    logic       rst_n;
    logic [W-1:0] acc;
    logic       flag_carry, flag_zero, flag_eq, flag_err, flag_ovf, done;

    au_seq_if #(.WIDTH(W)) bus ();

    au_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .acc        (acc),
        .flag_carry (flag_carry),
        .flag_zero  (flag_zero),
        .flag_eq    (flag_eq),
        .flag_err   (flag_err),
        .flag_ovf   (flag_ovf),
        .done       (done)
    );

    // Combinational arithmetic unit: A + (cin ? ~B : B) + cin, equality A==B.
    assign {bus.au_carry_out, bus.au_result} =
        {1'b0, bus.au_a} + {1'b0, (bus.au_carry_in ? ~bus.au_b : bus.au_b)} +
        {5'b0, bus.au_carry_in};
    assign bus.au_igualdade = (bus.au_a == bus.au_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0] acc;
        logic carry, zero, eq, err, ovf;
    } mst_t;

    function automatic int sgn(input logic [4:0] v);
        return v[4] ? int'(v) - 32 : int'(v);
    endfunction

    function automatic mst_t apply(input mst_t s, input logic [2:0] op, input logic [4:0] d);
        mst_t n = s;
        int a = int'(s.acc);
        int b = int'(d);
        case (op)
            3'd0: begin
                n.acc  = d;
                n.zero = (b == 0);
            end
            3'd1: begin
                n.acc   = 5'((a + b) % 32);
                n.carry = (a + b) >= 32;
                n.zero  = ((a + b) % 32) == 0;
`ifdef AU_SEQ_OVERFLOW_EN
                n.ovf   = (sgn(s.acc) + sgn(d) > 15) || (sgn(s.acc) + sgn(d) < -16);
`endif
            end
            3'd2: begin
                n.acc   = 5'((a - b + 32) % 32);
                n.carry = (a >= b);
                n.zero  = (a == b);
`ifdef AU_SEQ_OVERFLOW_EN
                n.ovf   = (sgn(s.acc) - sgn(d) > 15) || (sgn(s.acc) - sgn(d) < -16);
`endif
            end
            3'd3: n.eq = (a == b);
            3'd4: begin
                n      = '0;
                n.zero = 1'b1;
            end
            default: n.err = 1'b1;
        endcase
        return n;
    endfunction

    // Command-level timing: cycles since acceptance (0 = ready for a command).
    int         m_age;
    logic [2:0] m_op;
    logic [4:0] m_data;
    mst_t       m_st;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_age  <= 0;
            m_op   <= 3'd0;
            m_data <= '0;
            m_st   <= '0;
        end else if (m_age == 0) begin
            if (bus.cmd_valid) begin
                m_op   <= bus.cmd_op;
                m_data <= bus.cmd_data;
                m_age  <= 1;
            end
        end else if (m_age == 1) begin
            m_st  <= apply(m_st, m_op, m_data);
            m_age <= 2;
        end else begin
            m_age <= 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && started) begin
            check("cmp_ready",   32'(bus.cmd_ready),   32'(m_age == 0));
            check("cmp_done",    32'(done),            32'(m_age == 2));
            check("cmp_acc",     32'(acc),             32'(m_st.acc));
            check("cmp_au_a",    32'(bus.au_a),        32'(m_st.acc));
            check("cmp_au_b",    32'(bus.au_b),        32'(m_data));
            check("cmp_cin",     32'(bus.au_carry_in), 32'(m_age == 1 && m_op == 3'd2));
            check("cmp_chave",   32'(bus.au_chave),    32'(m_age == 1 && m_op == 3'd3));
            check("cmp_carry",   32'(flag_carry),      32'(m_st.carry));
            check("cmp_zero",    32'(flag_zero),       32'(m_st.zero));
            check("cmp_eq",      32'(flag_eq),         32'(m_st.eq));
            check("cmp_err",     32'(flag_err),        32'(m_st.err));
            check("cmp_ovf",     32'(flag_ovf),        32'(m_st.ovf));
        end
    end

    // ---------------- directed stimulus helpers ----------------
    logic exec_cin, exec_chave;

    // Issues one command, scrambles the inputs after acceptance, and returns
    // at the falling edge inside RESP.
    task automatic run_cmd(input logic [2:0] op, input logic [4:0] d);
        int n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) check("ready_wait", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'($urandom);
        bus.cmd_data  = 5'($urandom);
        @(negedge clk);
        exec_cin   = bus.au_carry_in;
        exec_chave = bus.au_chave;
        @(negedge clk);
        check("resp_done",  32'(done),          32'd1);
        check("resp_ready", 32'(bus.cmd_ready), 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_data  = '0;
        @(negedge clk);
        @(negedge clk);
        // Reset values
        check("rst_acc",   32'(acc),           32'd0);
        check("rst_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_done",  32'(done),          32'd0);
        check("rst_flags", 32'({flag_carry, flag_zero, flag_eq, flag_err, flag_ovf}), 32'd0);
        check("rst_au_b",  32'(bus.au_b),      32'd0);
        check("rst_cin",   32'({bus.au_carry_in, bus.au_chave}), 32'd0);
        rst_n   = 1'b1;
        started = 1'b1;

        // LOAD then ADD
        run_cmd(3'd0, 5'b01100);
        check("load_acc",  32'(acc),       32'd12);
        check("load_zero", 32'(flag_zero), 32'd0);
        @(negedge clk);
        check("load_done_end", 32'(done),          32'd0);
        check("load_ready",    32'(bus.cmd_ready), 32'd1);
        run_cmd(3'd1, 5'b00110);
        check("add_acc",   32'(acc),        32'd18);
        check("add_carry", 32'(flag_carry), 32'd0);
`ifdef AU_SEQ_OVERFLOW_EN
        check("add_ovf",   32'(flag_ovf),   32'd1);
`else
        check("add_ovf",   32'(flag_ovf),   32'd0);
`endif

        // SUB with and without borrow
        run_cmd(3'd0, 5'b01100);
        run_cmd(3'd2, 5'b00110);
        check("sub_cin",   32'(exec_cin),   32'd1);
        check("sub_acc",   32'(acc),        32'd6);
        check("sub_carry", 32'(flag_carry), 32'd1);
        run_cmd(3'd2, 5'b01000);
        check("sub2_acc",   32'(acc),        32'd30);
        check("sub2_carry", 32'(flag_carry), 32'd0);

        // Compare
        run_cmd(3'd0, 5'b01100);
        run_cmd(3'd3, 5'b01100);
        check("cmp_chave_exec", 32'(exec_chave), 32'd1);
        check("cmp_eq1",        32'(flag_eq),    32'd1);
        check("cmp_acc_kept",   32'(acc),        32'd12);
        run_cmd(3'd3, 5'b01010);
        check("cmp_eq0", 32'(flag_eq), 32'd0);

        // Wrap, illegal op, clear
        run_cmd(3'd0, 5'b11111);
        run_cmd(3'd1, 5'b00001);
        check("wrap_acc",   32'(acc),        32'd0);
        check("wrap_carry", 32'(flag_carry), 32'd1);
        check("wrap_zero",  32'(flag_zero),  32'd1);
        run_cmd(3'd6, 5'b10101);
        check("ill_err", 32'(flag_err), 32'd1);
        check("ill_acc", 32'(acc),      32'd0);
        run_cmd(3'd4, 5'b00000);
        check("clr_flags", 32'({flag_carry, flag_zero, flag_eq, flag_err, flag_ovf}), 32'b01000);
        check("clr_acc",   32'(acc), 32'd0);

        // Reset during EXEC aborts the command
        run_cmd(3'd0, 5'b01100);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd1;
        bus.cmd_data  = 5'b00101;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_acc",   32'(acc),           32'd0);
        check("abort_done",  32'(done),          32'd0);
        check("abort_ready", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        check("abort_done2", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_acc2",  32'(acc),           32'd0);

        // cmd_valid held through RESP is only taken once IDLE again
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd0;
        bus.cmd_data  = 5'd3;
        @(posedge clk);
        #1;
        bus.cmd_data  = 5'd7;
        @(negedge clk);
        @(negedge clk);
        check("hold_resp_acc",   32'(acc),           32'd3);
        check("hold_resp_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        check("hold_idle_acc",   32'(acc),           32'd3);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("hold_second_acc", 32'(acc), 32'd7);

        // Randomized traffic, including valid asserted while busy
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            bus.cmd_valid = ($urandom_range(0, 99) < 60);
            bus.cmd_op    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: bus.cmd_data = 5'd0;
                    1: bus.cmd_data = 5'd31;
                    2: bus.cmd_data = 5'd16;
                    default: bus.cmd_data = 5'd15;
                endcase
            end else begin
                bus.cmd_data = 5'($urandom);
            end
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/au_sequencer.md
# au_sequencer

Command-driven controller for the 5-bit arithmetic unit, which is purely combinational. It accepts one operation at a time over a valid/ready handshake and drives the unit's operand, carry-in and compare-select inputs from registers. It samples the unit's result, carry and equality outputs one cycle later. The result is kept in an accumulator with status flags, so back-to-back commands chain arithmetic (accumulate, subtract, compare) without external glue.

## Interface
- WIDTH, 5, datapath width; must match the arithmetic unit.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (IDLE only)
- cmd_op  in  3  operation code: 000 LOAD, 001 ADD, 010 SUB, 011 CMP, 100 CLR; 101–111 illegal
- cmd_data  in  WIDTH  operand
- au_a  out  WIDTH  unit operand A; always equals acc
- au_b  out  WIDTH  unit operand B; registered cmd_data
- au_carry_in  out  1  unit carry-in / invert select; 1 only in EXEC for SUB
- au_chave  out  1  unit compare select; 1 only in EXEC for CMP
- au_result  in  WIDTH  unit result
- au_carry_out  in  1  unit carry-out
- au_igualdade  in  1  unit equality (A==B)
- acc  out  WIDTH  accumulator
- flag_carry, flag_zero, flag_eq, flag_err, flag_ovf  out  1 each  status flags
- done  out  1  one-cycle pulse when a command retires

## Operation
- **IDLE**
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at a rising edge: latch op and data, go to EXEC.
- **EXEC** (one cycle)
  - Drive au_* from the latched fields.
  - At the closing edge, update acc and flags per op, go to RESP.
- **RESP** (one cycle)
  - done=1, cmd_ready=0.
  - Go to IDLE at the next edge.
- **LOAD**
  - acc<=data.
  - flag_zero<=(data==0).
  - carry, eq unchanged.
- **ADD**
  - acc<=au_result (acc+data mod 2^WIDTH).
  - flag_carry<=au_carry_out.
  - flag_zero updated.
- **SUB**
  - au_carry_in=1, so the unit computes acc+~data+1.
  - acc<=au_result.
  - flag_carry<=au_carry_out (1 = no borrow).
  - flag_zero updated.
- **CMP**
  - au_chave=1.
  - flag_eq<=au_igualdade.
  - acc, carry and zero unchanged; au_result is ignored.
- **CLR**
  - acc<=0.
  - carry, eq, err, ovf <= 0.
  - flag_zero<=1.
- **Illegal op**
  - acc unchanged.
  - flag_err<=1, cleared only by CLR or reset.
  - Still retires with done.
- flag_eq is left unchanged by every op except CMP and CLR.

## Timing
- Handshake at edge E0 → EXEC during E0–E1 → acc/flags valid after E1 → done high E1–E2 → cmd_ready high after E2.
- Latency is 2 cycles; throughput is 1 command per 3 cycles.
- cmd_valid while cmd_ready=0 is ignored. No queuing; the source holds the command.
- cmd_op/cmd_data may change freely after acceptance, because they are latched at acceptance.
- Reset values:
  - state=IDLE, cmd_ready=1, acc=0, all flags 0, done=0.
  - au_b=0, au_carry_in=0, au_chave=0.
- Reset asserted mid-EXEC or mid-RESP:
  - The command is aborted immediately (asynchronous).
  - No acc/flag update, and no done pulse.
- Wrap-around: arithmetic is modulo 2^WIDTH; carry reports the wrap.

## Configuration
- AU_SEQ_OVERFLOW_EN defined:
  - On ADD/SUB, flag_ovf<=signed (two's-complement) overflow = (sA==sB')&(sR!=sA).
  - sA is acc[MSB], sB' is au_b[MSB] xor au_carry_in, sR is au_result[MSB].
  - LOAD, CMP and illegal ops leave flag_ovf unchanged; CLR clears it.
- Undefined: the flag_ovf port remains and is tied to 0.

## Structure
- Shared package au_seq_pkg:
  - op-code constants (OP_LOAD…OP_CLR)
  - state enum (IDLE, EXEC, RESP)
  - default WIDTH
- One sub-module, au_seq_flags:
  - combinational next-flag/next-acc logic from op, acc, au_* inputs.
- The top holds the FSM, the registers and the handshake.

## Test plan
- Reset, then LOAD 01100 → after 2 cycles acc=01100, zero=0, done pulse of 1 cycle, cmd_ready back after 3 cycles.
- ADD 00110 after that LOAD → acc=10010, carry=0; with macro, ovf=1 (01100+00110 overflows signed 5-bit).
- LOAD 01100, SUB 00110 → au_carry_in=1 in EXEC, acc=00110, carry=1; then SUB 01000 → acc=11110, carry=0.
- Compare:
  - LOAD 01100, CMP 01100 → au_chave=1 in EXEC, eq=1, acc still 01100.
  - CMP 01010 → eq=0.
- LOAD 11111, ADD 00001 → acc=00000, carry=1, zero=1; then op 110 → err=1, acc unchanged, done pulses; CLR → all flags 0, zero=1.
- Accept ADD, assert rst_n low during EXEC → acc=0, no done, cmd_ready=1 after release; cmd_valid held during RESP is not accepted until IDLE.
